// File: rtl/mux_rr_nch.sv
// N-channel to one registered output multiplexer with fixed-select or round-robin arbitration.
// Optional packet locking (in_last/out_last) is compiled in with `define MUX_RR_NCH_LAST_EN.
module mux_rr_nch #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    localparam int SELW = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
`ifdef MUX_RR_NCH_LAST_EN
    input  logic [NCH-1:0]       in_last,
    output logic                 out_last,
`endif
    output logic [NCH-1:0]       in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    input  logic                 out_ready
);

    localparam int unsigned     NCH_U   = NCH;
    localparam logic [SELW:0]   NCH_W   = (SELW+1)'(NCH);
    localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);

    logic             load;
    logic             gvalid;
    logic [SELW-1:0]  gidx;
    logic [SELW-1:0]  cand;
    logic [SELW-1:0]  ptr;
    logic [WIDTH-1:0] chan [NCH];

`ifdef MUX_RR_NCH_LAST_EN
    logic            locked;
    logic [SELW-1:0] lock_ch;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_unpack
            assign chan[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign load = !out_valid || out_ready;

    // An active lock overrides both fixed select and the round-robin pointer.
    always_comb begin
        gvalid = 1'b0;
        gidx   = '0;
        cand   = '0;
`ifdef MUX_RR_NCH_LAST_EN
        if (locked) begin
            gvalid = in_valid[lock_ch];
            gidx   = lock_ch;
        end else
`endif
        if (!mode) begin
            if ({1'b0, sel} < NCH_W) begin
                gvalid = in_valid[sel];
                gidx   = sel;
            end
        end else begin
            for (int unsigned k = 0; k < NCH_U; k++) begin
                cand = SELW'((32'(ptr) + k) % NCH_U);
                if (!gvalid && in_valid[cand]) begin
                    gvalid = 1'b1;
                    gidx   = cand;
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (load && gvalid && !rst)
            in_ready[gidx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
`ifdef MUX_RR_NCH_LAST_EN
            out_last  <= 1'b0;
            locked    <= 1'b0;
            lock_ch   <= '0;
`endif
        end else if (load) begin
            if (gvalid) begin
                out_valid <= 1'b1;
                out_data  <= chan[gidx];
                out_ch    <= gidx;
                if (mode)
                    ptr <= (gidx == LAST_CH) ? '0 : gidx + SELW'(1);
`ifdef MUX_RR_NCH_LAST_EN
                out_last <= in_last[gidx];
                locked   <= !in_last[gidx];
                lock_ch  <= gidx;
`endif
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_nch.sv
// Self-checking bench for mux_rr_nch: directed vector table, hand sequences, and randomized
// traffic against a cycle-level reference model (honours MUX_RR_NCH_LAST_EN when defined).
module tb_mux_rr_nch;

    localparam int NCH = 4;
    localparam int W   = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             mode;
    logic [1:0]       sel;
    logic [NCH-1:0]   in_valid;
    logic [NCH*W-1:0] in_data;
    logic [NCH-1:0]   in_last;
    logic [NCH-1:0]   in_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [1:0]       out_ch;
    logic             out_ready;
    logic             out_last;
    logic [W-1:0]     chd [NCH];

    logic        mode6;
    logic [2:0]  sel6;
    logic [5:0]  valid6;
    logic [47:0] data6;
    logic [5:0]  last6;
    logic [5:0]  ready6;
    logic        ov6;
    logic [7:0]  od6;
    logic [2:0]  och6;
    logic        ordy6;
    logic        olast6;

    int total = 0;
    int bad   = 0;

    // reference model state
    int       m_ptr;
    bit       m_v;
    bit [7:0] m_d;
    int       m_ch;
    bit       m_lock;
    int       m_lch;
    bit       m_last;

    always #5 clk = ~clk;

    always_comb begin
        in_data = '0;
        for (int i = 0; i < NCH; i++) in_data[i*W +: W] = chd[i];
    end

    mux_rr_nch #(.WIDTH(W), .NCH(NCH)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data),
`ifdef MUX_RR_NCH_LAST_EN
        .in_last(in_last), .out_last(out_last),
`endif
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ch(out_ch), .out_ready(out_ready)
    );

    mux_rr_nch #(.WIDTH(8), .NCH(6)) dut6 (
        .clk(clk), .rst(rst), .mode(mode6), .sel(sel6),
        .in_valid(valid6), .in_data(data6),
`ifdef MUX_RR_NCH_LAST_EN
        .in_last(last6), .out_last(olast6),
`endif
        .in_ready(ready6), .out_valid(ov6), .out_data(od6),
        .out_ch(och6), .out_ready(ordy6)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Spec rules: backpressure blocks everything; a lock pins the channel; otherwise fixed or rotating search.
    function automatic int pick();
        if (m_v && !out_ready) return -1;
`ifdef MUX_RR_NCH_LAST_EN
        if (m_lock) return in_valid[m_lch] ? m_lch : -1;
`endif
        if (mode == 1'b0) return in_valid[sel] ? int'(sel) : -1;
        for (int d = 0; d < NCH; d++) begin
            int c;
            c = (m_ptr + d) % NCH;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic step(output logic [3:0] seen);
        int g;
        #1;
        g = pick();
        seen = in_ready;
        chk("in_ready", seen, (g >= 0) ? (64'd1 << g) : 64'd0);
        @(posedge clk);
        if (!m_v || out_ready) begin
            if (g >= 0) begin
                m_v  = 1'b1;
                m_d  = chd[g];
                m_ch = g;
                if (mode) m_ptr = (g + 1) % NCH;
`ifdef MUX_RR_NCH_LAST_EN
                m_last = in_last[g];
                m_lock = !in_last[g];
                m_lch  = g;
`endif
            end else begin
                m_v = 1'b0;
            end
        end
        #1;
        chk("out_valid", out_valid, m_v);
        chk("out_ch", out_ch, m_ch);
        chk("out_data", out_data, m_d);
`ifdef MUX_RR_NCH_LAST_EN
        chk("out_last", out_last, m_last);
`endif
    endtask

    task automatic do_reset();
        mode = 1'b1; in_valid = '1; out_ready = 1'b1;
        mode6 = 1'b1; valid6 = '1;
        rst = 1'b1;
        #1;
        chk("rst_async_valid", out_valid, 0);
        chk("rst_async_data", out_data, 0);
        chk("rst_async_ch", out_ch, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_in_ready6", ready6, 0);
        @(posedge clk); #1;
        chk("rst_hold_valid", out_valid, 0);
        chk("rst_hold_ready", in_ready, 0);
        rst = 1'b0;
        m_ptr = 0; m_v = 0; m_d = '0; m_ch = 0; m_lock = 0; m_lch = 0; m_last = 0;
    endtask

    typedef struct {
        bit         m;
        logic [1:0] s;
        logic [3:0] v;
        bit         r;
        logic [3:0] rdy;
        bit         ev;
        int         ech;
        logic [7:0] ed;
    } row_t;

    row_t tbl [15];

    initial begin
        logic [3:0] seen;

        tbl[0]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 0, 8'h00};
        tbl[1]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0010, 1'b1, 1, 8'h11};
        tbl[2]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0100, 1'b1, 2, 8'h22};
        tbl[3]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b1000, 1'b1, 3, 8'h33};
        tbl[4]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 0, 8'h00};
        tbl[5]  = '{1'b1, 2'd0, 4'hA, 1'b1, 4'b0010, 1'b1, 1, 8'h11};
        tbl[6]  = '{1'b1, 2'd0, 4'hA, 1'b1, 4'b1000, 1'b1, 3, 8'h33};
        tbl[7]  = '{1'b1, 2'd0, 4'hA, 1'b1, 4'b0010, 1'b1, 1, 8'h11};
        tbl[8]  = '{1'b1, 2'd0, 4'hA, 1'b1, 4'b1000, 1'b1, 3, 8'h33};
        tbl[9]  = '{1'b0, 2'd2, 4'h4, 1'b1, 4'b0100, 1'b1, 2, 8'h22};
        tbl[10] = '{1'b0, 2'd2, 4'h4, 1'b1, 4'b0100, 1'b1, 2, 8'h22};
        tbl[11] = '{1'b0, 2'd2, 4'hB, 1'b1, 4'b0000, 1'b0, 2, 8'h22};
        tbl[12] = '{1'b0, 2'd2, 4'h4, 1'b1, 4'b0100, 1'b1, 2, 8'h22};
        tbl[13] = '{1'b0, 2'd1, 4'h0, 1'b0, 4'b0000, 1'b1, 2, 8'h22};
        tbl[14] = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 0, 8'h00};

        for (int i = 0; i < NCH; i++) chd[i] = 8'(i * 8'h11);
        in_last = '1; sel = '0;
        sel6 = '0; data6 = 48'h554433221100; last6 = '1; ordy6 = 1'b1;
        do_reset();

        for (int i = 0; i < 15; i++) begin
            mode = tbl[i].m; sel = tbl[i].s; in_valid = tbl[i].v; out_ready = tbl[i].r;
            step(seen);
            chk($sformatf("tbl%0d_rdy", i), seen, tbl[i].rdy);
            chk($sformatf("tbl%0d_v", i), out_valid, tbl[i].ev);
            chk($sformatf("tbl%0d_ch", i), out_ch, tbl[i].ech);
            chk($sformatf("tbl%0d_d", i), out_data, tbl[i].ed);
        end

        // backpressure with 0x22 held
        mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        step(seen); step(seen);
        chk("bp_pre_data", out_data, 8'h22);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(seen);
            chk("bp_ready", seen, 0);
            chk("bp_hold_data", out_data, 8'h22);
            chk("bp_hold_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        step(seen);
        chk("bp_resume_rdy", seen, 4'b1000);
        chk("bp_resume_data", out_data, 8'h33);
        step(seen);
        chk("bp_next_data", out_data, 8'h00);

        // mid-stream reset: pointer is at 1 and a word is held
        do_reset();
        step(seen);
        chk("post_rst_rdy", seen, 4'b0001);
        chk("post_rst_ch", out_ch, 0);

        // out-of-range select on a 6-channel instance
        do_reset();
        mode6 = 1'b0; valid6 = '1; ordy6 = 1'b1;
        sel6 = 3'd7; #1;
        chk("sel7_ready6", ready6, 0);
        @(posedge clk); #1;
        chk("sel7_ov6", ov6, 0);
        sel6 = 3'd6; #1;
        chk("sel6_ready6", ready6, 0);
        @(posedge clk); #1;
        chk("sel6_ov6", ov6, 0);
        sel6 = 3'd5; #1;
        chk("sel5_ready6", ready6, 6'b100000);
        @(posedge clk); #1;
        chk("sel5_ov6", ov6, 1);
        chk("sel5_och6", och6, 5);
        chk("sel5_od6", od6, 8'h55);

`ifdef MUX_RR_NCH_LAST_EN
        do_reset();
        out_ready = 1'b1;
        mode = 1'b0; sel = 2'd1; in_valid = 4'b0111; in_last = 4'b0000;
        step(seen);
        chk("lock_b1_rdy", seen, 4'b0010);
        chk("lock_b1_ch", out_ch, 1);
        mode = 1'b1; in_valid = 4'b0101;
        step(seen);
        chk("lock_idle_rdy", seen, 0);
        chk("lock_idle_v", out_valid, 0);
        in_valid = 4'b0111;
        step(seen);
        chk("lock_b2_rdy", seen, 4'b0010);
        chk("lock_b2_ch", out_ch, 1);
        in_last = 4'b0010;
        step(seen);
        chk("lock_b3_rdy", seen, 4'b0010);
        chk("lock_b3_ch", out_ch, 1);
        chk("lock_b3_last", out_last, 1);
        in_last = 4'b1111;
        step(seen);
        chk("lock_after_ch", out_ch, 2);
`endif

        // randomized traffic against the model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            mode      = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NCH; i++) chd[i] = 8'($urandom);
`ifdef MUX_RR_NCH_LAST_EN
            in_last = 4'($urandom);
`else
            in_last = '1;
`endif
            step(seen);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
